// File: rtl/alu_srcb_stage.sv
// Registered operand-B source select for the ALU, buffered by a 2-entry skid buffer.
// Optional feature macro: ALUSRCB_STALL_CNT_EN adds a saturating stall counter output.
module alu_srcb_stage #(
  parameter int WIDTH   = 32,
  parameter int IMM_W   = 16,
  parameter int INC_VAL = 4,
  parameter int SHAMT   = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       selector,
  input  logic [WIDTH-1:0] data_memB,
  input  logic [IMM_W-1:0] imm,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] src_B,
  output logic [1:0]       src_sel_q,
  output logic             out_valid,
  input  logic             out_ready
`ifdef ALUSRCB_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] imm_sext, operand, s_data;
  logic [1:0]       s_sel;
  logic             s_valid, accept, consume;
  logic             load_m, load_s, pop_s;

  // A signed size cast sign-extends and also covers IMM_W == WIDTH.
  assign imm_sext = WIDTH'($signed(imm));

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    operand = data_memB;
    unique case (selector)
      2'b00: operand = data_memB;
      2'b01: operand = WIDTH'(INC_VAL);
      2'b10: operand = imm_sext << SHAMT;
      2'b11: operand = imm_sext;
      default: operand = data_memB;
    endcase
  end

  // Occupancy alone decides both valids, so in_ready comes straight off the state register.
  assign out_valid = (state != EMPTY);
  assign s_valid   = (state == FULL);
  assign in_ready  = !s_valid;
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    load_m    = 1'b0;
    load_s    = 1'b0;
    pop_s     = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          load_m    = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (consume && accept) begin
          load_m = 1'b1;
        end else if (consume) begin
          state_nxt = EMPTY;
        end else if (accept) begin
          load_s    = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        // in_ready is low here, so only the skid-to-main move can happen.
        if (consume) begin
          pop_s     = 1'b1;
          state_nxt = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_B     <= '0;
      src_sel_q <= 2'b00;
      s_data    <= '0;
      s_sel     <= 2'b00;
    end else begin
      if (load_m) begin
        src_B     <= operand;
        src_sel_q <= selector;
      end else if (pop_s) begin
        src_B     <= s_data;
        src_sel_q <= s_sel;
      end
      if (load_s) begin
        s_data <= operand;
        s_sel  <= selector;
      end
    end
  end

`ifdef ALUSRCB_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                    stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_alu_srcb_stage.sv
// Directed bench for alu_srcb_stage: source mux, skid fill/drain, async reset, narrow width,
// and the stall counter when ALUSRCB_STALL_CNT_EN is defined.
module tb_alu_srcb_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  selector;
  logic [31:0] data_memB;
  logic [15:0] imm;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] src_B;
  logic [1:0]  src_sel_q;

  logic [1:0]  selector8;
  logic [7:0]  data_memB8, imm8, src_B8;
  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [1:0]  src_sel_q8;

`ifdef ALUSRCB_STALL_CNT_EN
  logic [15:0] stall_cnt, stall_cnt8;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_srcb_stage dut (
    .clk(clk), .reset_n(reset_n), .selector(selector), .data_memB(data_memB), .imm(imm),
    .in_valid(in_valid), .in_ready(in_ready), .src_B(src_B), .src_sel_q(src_sel_q),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef ALUSRCB_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  alu_srcb_stage #(.WIDTH(8), .IMM_W(8), .INC_VAL(4), .SHAMT(2)) dut8 (
    .clk(clk), .reset_n(reset_n), .selector(selector8), .data_memB(data_memB8), .imm(imm8),
    .in_valid(in_valid8), .in_ready(in_ready8), .src_B(src_B8), .src_sel_q(src_sel_q8),
    .out_valid(out_valid8), .out_ready(out_ready8)
`ifdef ALUSRCB_STALL_CNT_EN
    , .stall_cnt(stall_cnt8)
`endif
  );

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; selector = 2'b00;
    data_memB = 32'h0; imm = 16'h0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; selector8 = 2'b00; data_memB8 = 8'h0; imm8 = 8'h0;
    #12;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_checks++; if (src_B !== 32'h0) begin n_fail++; $display("FAIL reset_src_B got %h exp 0", src_B); end
    n_checks++; if (src_sel_q !== 2'b00) begin n_fail++; $display("FAIL reset_src_sel_q got %b exp 00", src_sel_q); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_source_mux();
    logic [31:0] exp_b [4];
    exp_b[0] = 32'hDEADBEEF; exp_b[1] = 32'h00000004; exp_b[2] = 32'hFFFE0004; exp_b[3] = 32'hFFFF8001;
    data_memB = 32'hDEADBEEF; imm = 16'h8001; out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; selector = 2'(i);
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1 || src_B !== exp_b[i] || src_sel_q !== 2'(i)) begin
        n_fail++; $display("FAIL mux_sel%0d got v=%b b=%h s=%b exp v=1 b=%h s=%b", i, out_valid, src_B, src_sel_q, exp_b[i], 2'(i));
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || src_B !== 32'hFFFF8001) begin
      n_fail++; $display("FAIL mux_idle got v=%b b=%h exp v=0 b=ffff8001", out_valid, src_B);
    end
  endtask

  task automatic test_backpressure_fill();
    out_ready = 1'b0; selector = 2'b00;
    in_valid = 1'b1; data_memB = 32'h1111_1111;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || src_B !== 32'h1111_1111 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL fill_first got v=%b b=%h r=%b exp v=1 b=11111111 r=1", out_valid, src_B, in_ready);
    end
    data_memB = 32'h2222_2222;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0 || src_B !== 32'h1111_1111) begin
      n_fail++; $display("FAIL fill_full got r=%b b=%h exp r=0 b=11111111", in_ready, src_B);
    end
    data_memB = 32'h3333_3333;
    repeat (2) @(negedge clk);
    n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || src_B !== 32'h1111_1111) begin
      n_fail++; $display("FAIL fill_hold got r=%b v=%b b=%h exp r=0 v=1 b=11111111", in_ready, out_valid, src_B);
    end
  endtask

  task automatic test_drain_ordering();
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (src_B !== 32'h2222_2222 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL drain_second got b=%h v=%b r=%b exp b=22222222 v=1 r=1", src_B, out_valid, in_ready);
    end
    @(negedge clk);
    n_checks++; if (src_B !== 32'h3333_3333 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL drain_third got b=%h v=%b exp b=33333333 v=1", src_B, out_valid);
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || src_B !== 32'h3333_3333) begin
      n_fail++; $display("FAIL drain_empty got v=%b b=%h exp v=0 b=33333333", out_valid, src_B);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; selector = 2'b11; imm = 16'h0042;
    repeat (2) @(negedge clk);
    n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL areset_prefull got r=%b v=%b exp r=0 v=1", in_ready, out_valid);
    end
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || src_B !== 32'h0 || in_ready !== 1'b1 || src_sel_q !== 2'b00) begin
      n_fail++; $display("FAIL areset_immediate got v=%b b=%h r=%b s=%b exp v=0 b=0 r=1 s=00", out_valid, src_B, in_ready, src_sel_q);
    end
    @(negedge clk);
    reset_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1; selector = 2'b01;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || src_B !== 32'h4 || src_sel_q !== 2'b01) begin
      n_fail++; $display("FAIL areset_first got v=%b b=%h s=%b exp v=1 b=00000004 s=01", out_valid, src_B, src_sel_q);
    end
    @(negedge clk);
  endtask

  task automatic test_width_edge();
    logic [7:0] exp8 [4];
    exp8[0] = 8'h5A; exp8[1] = 8'h04; exp8[2] = 8'h04; exp8[3] = 8'hC1;
    imm8 = 8'hC1; data_memB8 = 8'h5A; out_ready8 = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      in_valid8 = 1'b1; selector8 = 2'(i);
      @(negedge clk);
      n_checks++; if (out_valid8 !== 1'b1 || src_B8 !== exp8[i] || src_sel_q8 !== 2'(i)) begin
        n_fail++; $display("FAIL width8_sel%0d got v=%b b=%h s=%b exp v=1 b=%h", i, out_valid8, src_B8, src_sel_q8, exp8[i]);
      end
    end
    in_valid8 = 1'b0;
    @(negedge clk);
  endtask

`ifdef ALUSRCB_STALL_CNT_EN
  task automatic test_stall_counter();
    reset_n = 1'b0;
    #1;
    n_checks++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL stall_reset got %h exp 0", stall_cnt); end
    @(negedge clk);
    reset_n = 1'b1; out_ready = 1'b0; in_valid = 1'b1; selector = 2'b00;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++; if (stall_cnt !== 16'd10) begin n_fail++; $display("FAIL stall_count10 got %0d exp 10", stall_cnt); end
    repeat (70000) @(negedge clk);
    n_checks++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL stall_saturate got %h exp ffff", stall_cnt); end
    repeat (5) @(negedge clk);
    n_checks++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL stall_hold got %h exp ffff", stall_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_source_mux();
    test_backpressure_fill();
    test_drain_ordering();
    test_async_reset();
    test_width_edge();
`ifdef ALUSRCB_STALL_CNT_EN
    test_stall_counter();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_srcb_stage.md
# alu_srcb_stage

Registered, parametrised operand-B stage for the ALU datapath. Each accepted transaction selects one of four sources: the B register, a constant increment, the sign-extended immediate, or that immediate shifted left. Sign extension and shift are computed internally. The result is held in a 2-entry skid buffer behind a valid/ready handshake, so the control FSM can issue at one operand per cycle while the ALU stalls freely.

## Interface
Parameters:
- WIDTH, 32, datapath width of data_memB and src_B
- IMM_W, 16, raw immediate width; must be ≥2 and ≤WIDTH
- INC_VAL, 4, constant for selector 01; truncated to WIDTH bits
- SHAMT, 2, left-shift amount for selector 10; must be <WIDTH

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- selector  in  2  source select, sampled on accept
- data_memB  in  WIDTH  B register value
- imm  in  IMM_W  raw immediate from the instruction
- in_valid  in  1  upstream offers selector/data
- in_ready  out  1  stage can accept
- src_B  out  WIDTH  selected operand
- src_sel_q  out  2  selector that produced src_B
- out_valid  out  1  src_B valid
- out_ready  in  1  ALU consumes src_B
- stall_cnt  out  16  present only with ALUSRCB_STALL_CNT_EN

## Operation
- Source encoding: 00 data_memB; 01 INC_VAL; 10 sext(imm) << SHAMT; 11 sext(imm).
- sext: replicate imm[IMM_W-1] up to WIDTH bits. The shift discards bits beyond WIDTH and fills with zeros.
- Storage: a main register (M) drives src_B, src_sel_q and out_valid. A skid register (S) has its own S_valid.
- in_ready = !S_valid, driven from a register and independent of same-cycle inputs.
- Accept = in_valid & in_ready. Consume = out_valid & out_ready.
- Per clock edge:
  - If M is empty, or M is consumed and S is empty: accepted data loads M.
  - If M is full and not consumed: accepted data loads S.
  - If M is consumed and S is full: S moves to M and S empties. in_ready was 0, so nothing is accepted that cycle.
  - If M is consumed, S is empty and nothing is accepted: out_valid falls.
- States by occupancy: EMPTY, ONE (M only), FULL (M and S).
  - EMPTY → ONE on accept.
  - ONE → ONE on accept with consume, or on neither.
  - ONE → FULL on accept without consume.
  - ONE → EMPTY on consume without accept.
  - FULL → ONE on consume; FULL holds otherwise.
- Ordering: strictly FIFO. Data is never dropped or duplicated.
- When out_valid=0, src_B and src_sel_q hold their last values.
- Inputs are ignored when in_valid=0 or in_ready=0.

## Timing
- Reset values (asynchronous, while reset_n=0): out_valid=0, S_valid=0, src_B=0, src_sel_q=00, stall_cnt=0. in_ready=1.
- Reset mid-operation discards both entries immediately. After reset_n rises, the first accept may occur on the first clock edge.
- Latency: accept at edge N → out_valid=1 after edge N. There is no combinational path from inputs to src_B.
- Throughput: 1 operand per cycle while out_ready=1.
- in_ready falls the cycle after the stage becomes FULL. It rises the cycle after S drains.
- Backpressure: src_B and src_sel_q are stable while out_valid=1 and out_ready=0.

## Configuration
- ALUSRCB_STALL_CNT_EN defined:
  - stall_cnt increments each cycle where out_valid=1 and out_ready=0.
  - It saturates at 16'hFFFF and clears only on reset.
- Undefined: the stall_cnt port and its counter are absent. All other behaviour is identical.

## Test plan
- Source mux:
  - Stimulus: WIDTH=32, imm=16'h8001, data_memB=32'hDEADBEEF, out_ready=1; issue selectors 00, 01, 10, 11 on consecutive cycles.
  - Required: src_B = DEADBEEF, 00000004, FFFE0004, FFFF8001 on consecutive cycles starting one cycle after the first accept; src_sel_q matches each.
- Backpressure fill:
  - Stimulus: out_ready=0; in_valid=1 with three distinct operands.
  - Required: the first two are accepted; in_ready=0 from the cycle after the second accept; the third is held off; src_B stays on the first operand.
- Drain ordering:
  - Stimulus: from the FULL state, set out_ready=1 for 3 cycles while the third operand is still offered.
  - Required: outputs appear in order 1, 2, 3 with no loss or duplicate; out_valid=0 after the last unless new input arrives.
- Async reset:
  - Stimulus: assert reset_n=0 between clock edges while FULL.
  - Required: out_valid=0, src_B=0 and in_ready=1 immediately; the first operand after release appears one cycle after its accept.
- Width edge:
  - Stimulus: WIDTH=8, IMM_W=8, SHAMT=2, imm=8'hC1, selector=10.
  - Required: src_B = 8'h04.
- Stall counter (macro on):
  - Stimulus: hold out_valid=1, out_ready=0 for 70000 cycles.
  - Required: stall_cnt = 16'hFFFF and holds.
- Stall counter (macro off):
  - Required: the build has no stall_cnt port.
